score_keeper: RTL and testbench
===============================

# score_keeper

Game-side producer of the score/beep interface consumed by the seven-segment display driver. It turns point events from the ball/collision logic into two BCD scores (`p1`, `p2`, each 0–9) and a square-wave `beep` for the buzzer. It detects the winning score, freezes play, and clears on a new-game request. It sits between the game FSM and the display driver, in the same clock domain.

## Interface
Parameters:
- `WIN_SCORE`, default 9: score that ends the game; legal range 1–9.
- `BEEP_CYCLES`, default 5_000_000: beep duration for a normal point, in clk cycles.
- `TONE_HALF`, default 25_000: half-period of the beep square wave, in clk cycles.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `point_p1` in 1: level from game logic; a rising edge awards player 1 a point.
- `point_p2` in 1: level from game logic; a rising edge awards player 2 a point.
- `new_game` in 1: synchronous request; clears scores and returns to play.
- `p1` out 4: player 1 score, BCD 0–9.
- `p2` out 4: player 2 score, BCD 0–9.
- `beep` out 1: buzzer drive (square wave while sounding, else 0).
- `game_over` out 1: high while in OVER.
- `winner` out 2: 2'b00 none, 2'b01 player 1, 2'b10 player 2.

## Operation
**Edge detection**
- `point_p1` and `point_p2` are registered each cycle.
- An event is input=1 with the registered previous value=0.
- The previous-value registers reset to 1. A level already high out of reset does not score.

**FSM states**
- PLAY: accepts point events.
  - Exactly one event: increment that score. If the new value equals `WIN_SCORE`, go to OVER. Otherwise go to HOLD.
  - Both events in the same cycle: ignored. No score change, no beep, stay in PLAY.
- HOLD: beep sounding for `BEEP_CYCLES`. Point events are ignored. Return to PLAY when the duration counter expires.
- OVER: `game_over`=1 and `winner` set. Beep sounds for 2×`BEEP_CYCLES`, then silent. Scores frozen; point events ignored.

**`new_game`**
- In any state, `new_game`=1 clears both scores, `winner`, `game_over`, the duration counter and the tone counter. Next state is PLAY, next `beep` is 0.
- `new_game` has priority over a simultaneous point event.

**Arithmetic and widths**
- Scores are 4-bit and never exceed `WIN_SCORE`, so no wrap occurs.
- Duration counter width is $clog2(2×`BEEP_CYCLES`+1).
- Tone counter width is $clog2(`TONE_HALF`).

**Beep**
- `beep` toggles every `TONE_HALF` cycles while sounding. It starts at 1 on the first sounding cycle.
- It is forced to 0 when not sounding.

## Timing
- Reset values: `p1`=0, `p2`=0, `beep`=0, `game_over`=0, `winner`=00, state=PLAY. All outputs are registered.
- Point latency: an event in cycle N (sampled at clk edge E) updates the score and sets `beep`=1 at edge E. Both are visible in cycle N+1.
- Beep length: `beep` is in its sounding window for exactly `BEEP_CYCLES` cycles after a point, then returns to 0 at the same edge as HOLD→PLAY.
- Game end: the game-ending score, `game_over`=1 and `winner` all update at the same edge.
- Re-arming: a point level that stays high through HOLD does not re-trigger. A new rising edge is required after return to PLAY.
- Reset mid-HOLD or mid-OVER: all outputs return to their reset values asynchronously.

## Structure
- Shared package `pong_pkg`:
  - `state_t` enum {PLAY, HOLD, OVER}.
  - `SCORE_W`=4.
  - `winner_t` codes `WIN_NONE`, `WIN_P1`, `WIN_P2`.
  - These are reused by the display driver and the game FSM.
- One sub-module, `tone_gen`:
  - Inputs: `clk`, `rst_n`, `en`, parameter `TONE_HALF`.
  - Output: registered square wave, 0 when `en`=0, phase reset on `en` rising.
  - The FSM and score logic stay in `score_keeper`.

## Test plan
Bench parameters: `WIN_SCORE`=3, `BEEP_CYCLES`=8, `TONE_HALF`=2.

1. Reset release with `point_p1` held at 1 → `p1`=0, `beep`=0 for 20 cycles.
2. One-cycle pulse on `point_p1` → `p1`=1 next cycle. `beep` pattern 1,1,0,0,1,1,0,0 for 8 cycles, then 0. A second pulse during HOLD is ignored (`p1` stays 1).
3. `point_p1` and `point_p2` rise in the same cycle → `p1` and `p2` unchanged, `beep` stays 0.
4. Three separated `point_p2` pulses → `p2`=3, `game_over`=1, `winner`=10 at the same edge. Beep lasts 16 cycles. A further `point_p1` pulse leaves `p1` unchanged.
5. `new_game` asserted in OVER together with a `point_p1` edge → next cycle `p1`=`p2`=0, `game_over`=0, `winner`=00, `beep`=0.
6. `rst_n` asserted low mid-HOLD (`p1`=2) → all outputs return to their reset values immediately, before the next clk edge.

Source files
------------

// File: rtl/pong_pkg.sv
// Types and widths shared by the score keeper, the game FSM and the seven-segment driver.
package pong_pkg;

  localparam int SCORE_W = 4;

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    HOLD = 2'd1,
    OVER = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10
  } winner_t;

endpackage

// File: rtl/tone_gen.sv
// Buzzer square wave: high on the first enabled cycle, toggles every TONE_HALF cycles, 0 when disabled.
module tone_gen #(
  parameter int TONE_HALF = 25_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tone
);

  localparam int TW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(TONE_HALF - 1);

  logic          r_en_d;
  logic [TW-1:0] r_cnt;
  logic          r_tone;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_d <= 1'b0;
      r_cnt  <= '0;
      r_tone <= 1'b0;
    end else begin
      r_en_d <= en;
      if (!en) begin
        r_tone <= 1'b0;
        r_cnt  <= RELOAD;
      end else if (!r_en_d) begin
        // phase restarts on every new sounding window
        r_tone <= 1'b1;
        r_cnt  <= RELOAD;
      end else if (r_cnt == '0) begin
        r_tone <= ~r_tone;
        r_cnt  <= RELOAD;
      end else begin
        r_cnt <= r_cnt - TW'(1);
      end
    end
  end

  assign tone = r_tone;

endmodule

// File: rtl/score_keeper.sv
// Turns point edges into two BCD scores, a beep window and a game-over/winner indication.
//   state | meaning
//   PLAY  | accepting point events
//   HOLD  | point just scored, beep sounding, events ignored
//   OVER  | winning score reached, scores frozen until new_game
module score_keeper
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = 9,
  parameter int BEEP_CYCLES = 5_000_000,
  parameter int TONE_HALF   = 25_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               point_p1,
  input  logic               point_p2,
  input  logic               new_game,
  output logic [SCORE_W-1:0] p1,
  output logic [SCORE_W-1:0] p2,
  output logic               beep,
  output logic               game_over,
  output logic [1:0]         winner
);

  localparam int DW = $clog2(2 * BEEP_CYCLES + 1);
  localparam logic [DW-1:0]      HOLD_LOAD = DW'(BEEP_CYCLES - 1);
  localparam logic [DW-1:0]      OVER_LOAD = DW'(2 * BEEP_CYCLES - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);

  logic               r_prev_p1, r_prev_p2;
  state_t             r_state, w_state_nxt;
  logic [SCORE_W-1:0] r_p1, r_p2, w_p1_nxt, w_p2_nxt;
  logic [DW-1:0]      r_dur, w_dur_nxt;
  winner_t            r_winner, w_winner_nxt;
  logic               r_game_over, w_go_nxt;
  logic               w_ev_p1, w_ev_p2, w_sound_nxt;
  logic [SCORE_W-1:0] w_p1_inc, w_p2_inc;

  assign w_ev_p1  = point_p1 & ~r_prev_p1;
  assign w_ev_p2  = point_p2 & ~r_prev_p2;
  assign w_p1_inc = r_p1 + SCORE_W'(1);
  assign w_p2_inc = r_p2 + SCORE_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_p1   <= 1'b1;
      r_prev_p2   <= 1'b1;
      r_state     <= PLAY;
      r_p1        <= '0;
      r_p2        <= '0;
      r_dur       <= '0;
      r_winner    <= WIN_NONE;
      r_game_over <= 1'b0;
    end else begin
      r_prev_p1   <= point_p1;
      r_prev_p2   <= point_p2;
      r_state     <= w_state_nxt;
      r_p1        <= w_p1_nxt;
      r_p2        <= w_p2_nxt;
      r_dur       <= w_dur_nxt;
      r_winner    <= w_winner_nxt;
      r_game_over <= w_go_nxt;
    end
  end

  // w_sound_nxt is the sounding window for the cycle after this edge.
  always_comb begin
    w_state_nxt  = r_state;
    w_p1_nxt     = r_p1;
    w_p2_nxt     = r_p2;
    w_dur_nxt    = r_dur;
    w_winner_nxt = r_winner;
    w_go_nxt     = r_game_over;
    w_sound_nxt  = 1'b0;
    if (new_game) begin
      w_state_nxt  = PLAY;
      w_p1_nxt     = '0;
      w_p2_nxt     = '0;
      w_dur_nxt    = '0;
      w_winner_nxt = WIN_NONE;
      w_go_nxt     = 1'b0;
    end else begin
      case (r_state)
        PLAY: begin
          if (w_ev_p1 && !w_ev_p2) begin
            w_p1_nxt    = w_p1_inc;
            w_sound_nxt = 1'b1;
            if (w_p1_inc == WIN_VAL) begin
              w_state_nxt  = OVER;
              w_go_nxt     = 1'b1;
              w_winner_nxt = WIN_P1;
              w_dur_nxt    = OVER_LOAD;
            end else begin
              w_state_nxt = HOLD;
              w_dur_nxt   = HOLD_LOAD;
            end
          end else if (w_ev_p2 && !w_ev_p1) begin
            w_p2_nxt    = w_p2_inc;
            w_sound_nxt = 1'b1;
            if (w_p2_inc == WIN_VAL) begin
              w_state_nxt  = OVER;
              w_go_nxt     = 1'b1;
              w_winner_nxt = WIN_P2;
              w_dur_nxt    = OVER_LOAD;
            end else begin
              w_state_nxt = HOLD;
              w_dur_nxt   = HOLD_LOAD;
            end
          end
        end
        HOLD: begin
          if (r_dur == '0) begin
            w_state_nxt = PLAY;
          end else begin
            w_dur_nxt   = r_dur - DW'(1);
            w_sound_nxt = 1'b1;
          end
        end
        OVER: begin
          if (r_dur != '0) begin
            w_dur_nxt   = r_dur - DW'(1);
            w_sound_nxt = 1'b1;
          end
        end
        default: w_state_nxt = PLAY;
      endcase
    end
  end

  tone_gen #(
    .TONE_HALF(TONE_HALF)
  ) u_tone (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (w_sound_nxt),
    .tone (beep)
  );

  assign p1        = r_p1;
  assign p2        = r_p2;
  assign game_over = r_game_over;
  assign winner    = r_winner;

endmodule

// File: tb/tb_score_keeper.sv
// Vector-table bench for score_keeper with a small scoreboard queue of expected outputs.
module tb_score_keeper;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       point_p1, point_p2, new_game;
  logic [3:0] p1, p2;
  logic       beep, game_over;
  logic [1:0] winner;

  always #5 clk = ~clk;

  score_keeper #(
    .WIN_SCORE  (3),
    .BEEP_CYCLES(8),
    .TONE_HALF  (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .point_p1 (point_p1),
    .point_p2 (point_p2),
    .new_game (new_game),
    .p1       (p1),
    .p2       (p2),
    .beep     (beep),
    .game_over(game_over),
    .winner   (winner)
  );

  typedef struct packed {
    logic [3:0] p1;
    logic [3:0] p2;
    logic       beep;
    logic       go;
    logic [1:0] win;
  } out_t;

  typedef struct {
    logic i1;
    logic i2;
    logic ng;
    out_t exp;
  } vec_t;

  vec_t vecs[$];
  out_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic bp(int k);
    return ((k / 2) % 2) == 0;
  endfunction

  function automatic out_t mk(logic [3:0] e1, logic [3:0] e2, logic eb, logic eg, logic [1:0] ew);
    out_t o;
    o.p1 = e1; o.p2 = e2; o.beep = eb; o.go = eg; o.win = ew;
    return o;
  endfunction

  function automatic void add(logic a, logic b, logic c, out_t e);
    vec_t v;
    v.i1 = a; v.i2 = b; v.ng = c; v.exp = e;
    vecs.push_back(v);
  endfunction

  function automatic out_t cur();
    out_t o;
    o.p1 = p1; o.p2 = p2; o.beep = beep; o.go = game_over; o.win = winner;
    return o;
  endfunction

  task automatic check(string name, out_t act, out_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got p1=%0d p2=%0d beep=%b game_over=%b winner=%b, expected p1=%0d p2=%0d beep=%b game_over=%b winner=%b",
               name, act.p1, act.p2, act.beep, act.go, act.win,
               exp.p1, exp.p2, exp.beep, exp.go, exp.win);
    end
  endtask

  task automatic step(logic a, logic b, logic c, out_t e, string name);
    out_t x;
    @(negedge clk);
    point_p1 = a; point_p2 = b; new_game = c;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check(name, cur(), x);
  endtask

  initial begin
    // reset release with point_p1 already high
    for (int i = 0; i < 20; i++) add(1, 0, 0, mk(0, 0, 0, 0, 0));
    // single p1 point, second pulse inside HOLD ignored
    add(0, 0, 0, mk(0, 0, 0, 0, 0));
    add(1, 0, 0, mk(1, 0, 1, 0, 0));
    for (int k = 1; k < 8; k++) add(k == 2, 0, 0, mk(1, 0, bp(k), 0, 0));
    add(0, 0, 0, mk(1, 0, 0, 0, 0));
    add(0, 0, 0, mk(1, 0, 0, 0, 0));
    // simultaneous edges ignored
    add(1, 1, 0, mk(1, 0, 0, 0, 0));
    add(1, 1, 0, mk(1, 0, 0, 0, 0));
    add(0, 0, 0, mk(1, 0, 0, 0, 0));
    add(0, 0, 0, mk(1, 0, 0, 0, 0));
    // player 2 wins with three points
    for (int n = 1; n <= 3; n++) begin
      add(0, 1, 0, mk(1, 4'(n), 1, n == 3, (n == 3) ? 2'b10 : 2'b00));
      if (n < 3) begin
        for (int k = 1; k < 8; k++) add(0, 0, 0, mk(1, 4'(n), bp(k), 0, 0));
        add(0, 0, 0, mk(1, 4'(n), 0, 0, 0));
      end else begin
        for (int k = 1; k < 16; k++) add(0, 0, 0, mk(1, 3, bp(k), 1, 2'b10));
      end
    end
    add(0, 0, 0, mk(1, 3, 0, 1, 2'b10));
    add(1, 0, 0, mk(1, 3, 0, 1, 2'b10));
    add(0, 0, 0, mk(1, 3, 0, 1, 2'b10));
    add(0, 0, 0, mk(1, 3, 0, 1, 2'b10));
    // new_game beats a simultaneous point edge
    add(1, 0, 1, mk(0, 0, 0, 0, 0));
    add(1, 0, 0, mk(0, 0, 0, 0, 0));
    add(0, 0, 0, mk(0, 0, 0, 0, 0));

    rst_n = 1'b0; point_p1 = 1'b1; point_p2 = 1'b0; new_game = 1'b0;
    #12;
    check("reset_state", cur(), mk(0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].i1, vecs[i].i2, vecs[i].ng, vecs[i].exp, $sformatf("vec%0d", i));

    // reset asserted mid-HOLD with p1=2
    step(1, 0, 0, mk(1, 0, 1, 0, 0), "rst_seq_pt1");
    for (int k = 1; k < 8; k++) step(0, 0, 0, mk(1, 0, bp(k), 0, 0), "rst_seq_hold1");
    step(0, 0, 0, mk(1, 0, 0, 0, 0), "rst_seq_play");
    step(1, 0, 0, mk(2, 0, 1, 0, 0), "rst_seq_pt2");
    step(0, 0, 0, mk(2, 0, 1, 0, 0), "rst_seq_hold2");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", cur(), mk(0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, mk(0, 0, 0, 0, 0), "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
